// File: rtl/pipe_add_pkg.sv
// -----------------------------------------------------------------------------
// pipe_add_pkg
// Shared constants and helpers for the pipelined valid/ready adder.
//   MIN_STAGES  smallest legal number of register slots
//   MIN_WIDTH   smallest legal operand/result width
//   config_ok() true when a (width, stages) pair is legal; used for
//               elaboration-time checks.
// The per-slot record {v, d} depends on WIDTH. A package typedef cannot take
// a parameter, so the record type slot_t is declared inside pipe_slot, where
// WIDTH is known.
// -----------------------------------------------------------------------------
package pipe_add_pkg;

    localparam int MIN_STAGES = 1;
    localparam int MIN_WIDTH  = 1;

    // Legal configuration check shared by the top and the slot.
    function automatic logic config_ok(input int width, input int stages);
        return (width >= MIN_WIDTH) && (stages >= MIN_STAGES);
    endfunction

endpackage

// File: rtl/pipe_add_valid_ready_if.sv
// -----------------------------------------------------------------------------
// pipe_add_valid_ready_if
// Bundle of the adder's operand/result handshake signals.
//   a, b       operands, offered with in_valid, taken when in_ready
//   in_valid   upstream offers (a, b)
//   in_ready   adder accepts (a, b) this cycle
//   c          sum from the last slot, meaningful while out_valid
//   out_valid  c holds a result
//   out_ready  downstream accepts c this cycle
// Modports: master = the environment around the adder, slave = the adder.
// -----------------------------------------------------------------------------
interface pipe_add_valid_ready_if #(
    parameter int WIDTH = 32
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, c, out_valid
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, c, out_valid
    );

endinterface

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One valid/data register slot of the stallable pipeline.
//   clk, rst_n  clock, synchronous active-low reset
//   up_valid    upstream slot (or input port) holds an item
//   up_data     that item
//   dn_ready    downstream slot (or output port) will take our item
//   valid       this slot holds an item
//   data        the held item
//   rdy         this slot takes up_data at the next posedge
// Optional build macro PIPE_ADD_DATA_RESET_EN: also clears the data register
// on reset; otherwise only the occupancy flag is reset.
// -----------------------------------------------------------------------------
module pipe_slot
    import pipe_add_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             rdy
);

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
    } slot_t;

    slot_t slot_r;
    logic  load_s;

    if (!config_ok(WIDTH, MIN_STAGES)) begin : g_bad_width
        $error("pipe_slot: WIDTH must be >= %0d", MIN_WIDTH);
    end

    // An empty slot always accepts, so bubbles collapse; a full one only
    // accepts when its item moves on in the same cycle.
    always_comb begin
        rdy    = !slot_r.v || dn_ready;
        load_s = rdy && up_valid;
    end

    // Slot state: occupancy follows the source whenever we can advance, data
    // is loaded only for a real item so bubbles do not toggle the register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_r.v <= 1'b0;
`ifdef PIPE_ADD_DATA_RESET_EN
            slot_r.d <= {WIDTH{1'b0}};
`else
            slot_r.d <= slot_r.d;
`endif
        end else begin
            if (rdy) begin
                slot_r.v <= up_valid;
            end else begin
                slot_r.v <= slot_r.v;
            end
            if (load_s) begin
                slot_r.d <= up_data;
            end else begin
                slot_r.d <= slot_r.d;
            end
        end
    end

    // Outputs come straight from the slot register.
    always_comb begin
        valid = slot_r.v;
        data  = slot_r.d;
    end

endmodule

// File: rtl/pipe_add_valid_ready.sv
// -----------------------------------------------------------------------------
// pipe_add_valid_ready
// Pipelined adder c = a + b mod 2^WIDTH with lossless valid/ready backpressure.
// NUM_STAGES independently stallable slots; latency NUM_STAGES, throughput 1.
//   clk    sole clock
//   rst_n  synchronous active-low reset; flushes all slots, in_ready = 0
//   bus    slave side of pipe_add_valid_ready_if (a, b, in_valid, in_ready,
//          c, out_valid, out_ready)
// Optional build macro PIPE_ADD_DATA_RESET_EN: data registers reset to zero,
// so c = 0 after reset. Default build resets only the valid flags.
// The ready chain runs combinationally from out_ready to in_ready through one
// AND/OR level per slot; this is intentional.
// -----------------------------------------------------------------------------
module pipe_add_valid_ready
    import pipe_add_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_STAGES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_add_valid_ready_if.slave bus
);

    logic [WIDTH-1:0] sum_s;

    if (!config_ok(WIDTH, NUM_STAGES)) begin : g_bad_config
        $error("pipe_add_valid_ready: need WIDTH >= %0d and NUM_STAGES >= %0d",
               MIN_WIDTH, MIN_STAGES);
    end

    // Adder ahead of slot 0; the carry out is dropped by the truncation.
    always_comb begin
        sum_s = bus.a + bus.b;
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic             up_valid_s;
        logic [WIDTH-1:0] up_data_s;
        logic             dn_ready_s;
        logic             valid_s;
        logic [WIDTH-1:0] data_s;
        logic             rdy_s;

        if (k == 0) begin : g_src_in
            assign up_valid_s = bus.in_valid;
            assign up_data_s  = sum_s;
        end else begin : g_src_prev
            assign up_valid_s = g_stage[k-1].valid_s;
            assign up_data_s  = g_stage[k-1].data_s;
        end

        if (k == NUM_STAGES - 1) begin : g_dn_out
            assign dn_ready_s = bus.out_ready;
        end else begin : g_dn_next
            assign dn_ready_s = g_stage[k+1].rdy_s;
        end

        pipe_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (up_valid_s),
            .up_data  (up_data_s),
            .dn_ready (dn_ready_s),
            .valid    (valid_s),
            .data     (data_s),
            .rdy      (rdy_s)
        );
    end

    // in_ready is forced low while reset is asserted so nothing is taken.
    assign bus.in_ready  = g_stage[0].rdy_s & rst_n;
    assign bus.out_valid = g_stage[NUM_STAGES-1].valid_s;
    assign bus.c         = g_stage[NUM_STAGES-1].data_s;

endmodule

// File: tb/tb_pipe_add_valid_ready.sv
// -----------------------------------------------------------------------------
// tb_pipe_add_valid_ready
// Three adders with NUM_STAGES = 1, 2, 3 (instance index + 1) share clock and
// reset. A transaction-level model (FIFO of expected sums, capacity N) checks
// every cycle: in_ready, ordering and value of every emitted result, c/valid
// stability while stalled, and no output from an empty pipeline.
// -----------------------------------------------------------------------------
module tb_pipe_add_valid_ready;

    localparam int W  = 32;
    localparam int NI = 3;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a_i [NI];
    logic [W-1:0] b_i [NI];
    logic         in_valid_i [NI];
    logic         out_ready_i [NI];
    logic         in_ready_o [NI];
    logic         out_valid_o [NI];
    logic [W-1:0] c_o [NI];

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_q [NI][$];
    logic         held [NI];
    logic [W-1:0] held_c [NI];
    logic         rdy_seen [NI];
    int           pops [NI];
    vec_t         vecs [6];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pipe_add_valid_ready_if #(.WIDTH(W)) bus ();

        assign bus.a         = a_i[g];
        assign bus.b         = b_i[g];
        assign bus.in_valid  = in_valid_i[g];
        assign bus.out_ready = out_ready_i[g];
        assign in_ready_o[g]  = bus.in_ready;
        assign out_valid_o[g] = bus.out_valid;
        assign c_o[g]         = bus.c;

        pipe_add_valid_ready #(
            .WIDTH      (W),
            .NUM_STAGES (g + 1)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One clock: sample just after the inputs settle, update the model with
    // the handshakes that the coming posedge will perform, then advance.
    task automatic cycle();
        #1;
        for (int i = 0; i < NI; i++) begin
            rdy_seen[i] = in_ready_o[i];
            if (!rst_n) begin
                chk1($sformatf("in_ready_during_reset[%0d]", i), in_ready_o[i], 1'b0);
            end else begin
                chk1($sformatf("in_ready[%0d]", i), in_ready_o[i],
                     (exp_q[i].size() < i + 1) || out_ready_i[i]);
                if (exp_q[i].size() == 0)
                    chk1($sformatf("out_valid_when_empty[%0d]", i), out_valid_o[i], 1'b0);
                if (held[i]) begin
                    chk1($sformatf("stall_valid[%0d]", i), out_valid_o[i], 1'b1);
                    chk($sformatf("stall_c[%0d]", i), c_o[i], held_c[i]);
                end
                if (out_valid_o[i] && out_ready_i[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk1($sformatf("spurious_output[%0d]", i), out_valid_o[i], 1'b0);
                    end else begin
                        pops[i]++;
                        chk($sformatf("result[%0d]", i), c_o[i], exp_q[i].pop_front());
                    end
                end
                if (in_valid_i[i] && in_ready_o[i])
                    exp_q[i].push_back(a_i[i] + b_i[i]);
                held[i]   = out_valid_o[i] && !out_ready_i[i];
                held_c[i] = c_o[i];
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                exp_q[i].delete();
                held[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int budget;
        int p0;

        vecs[0] = '{32'd5,          32'd7,          32'd12};
        vecs[1] = '{32'hFFFF_FFFF,  32'd2,          32'h0000_0001};
        vecs[2] = '{32'd0,          32'd0,          32'd0};
        vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
        vecs[4] = '{32'h8000_0000,  32'h8000_0000,  32'd0};
        vecs[5] = '{32'h1234_5678,  32'h1111_1111,  32'h2345_6789};

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            a_i[i] = 32'd0; b_i[i] = 32'd0;
            in_valid_i[i] = 1'b0; out_ready_i[i] = 1'b1;
            held[i] = 1'b0; pops[i] = 0;
        end
        @(negedge clk);
        cycle();
        cycle();
        for (int i = 0; i < NI; i++) begin
            chk1($sformatf("reset_out_valid[%0d]", i), out_valid_o[i], 1'b0);
`ifdef PIPE_ADD_DATA_RESET_EN
            chk($sformatf("reset_c_zero[%0d]", i), c_o[i], 32'd0);
`endif
        end
        rst_n = 1'b1;
        cycle();
        for (int i = 0; i < NI; i++)
            chk1($sformatf("ready_after_release[%0d]", i), rdy_seen[i], 1'b1);

        // Table vectors through N=3: result appears exactly 3 cycles after accept.
        for (int v = 0; v < 6; v++) begin
            a_i[2] = vecs[v].a; b_i[2] = vecs[v].b; in_valid_i[2] = 1'b1;
            cycle();
            in_valid_i[2] = 1'b0;
            for (int j = 1; j <= 4; j++) begin
                chk1($sformatf("latency_valid v%0d c%0d", v, j), out_valid_o[2], (j == 3));
                if (j == 3) chk($sformatf("table_sum v%0d", v), c_o[2], vecs[v].c);
                cycle();
            end
        end

        // N=3 stalled: only 3 of 5 back-to-back items fit, then drain all 5.
        out_ready_i[2] = 1'b0;
        acc = 0;
        p0  = pops[2];
        for (int n = 0; n < 6; n++) begin
            a_i[2] = 32'd100 + 32'(acc); b_i[2] = 32'(acc * 7); in_valid_i[2] = 1'b1;
            cycle();
            if (rdy_seen[2]) acc++;
        end
        chk("stalled_accepts", 32'(acc), 32'd3);
        chk1("stalled_in_ready", rdy_seen[2], 1'b0);
        chk1("stalled_out_valid", out_valid_o[2], 1'b1);
        out_ready_i[2] = 1'b1;
        budget = 20;
        while (acc < 5 && budget > 0) begin
            a_i[2] = 32'd100 + 32'(acc); b_i[2] = 32'(acc * 7); in_valid_i[2] = 1'b1;
            cycle();
            if (rdy_seen[2]) acc++;
            budget--;
        end
        in_valid_i[2] = 1'b0;
        for (int n = 0; n < 8; n++) cycle();
        chk("stall_total_accepts", 32'(acc), 32'd5);
        chk("stall_total_emitted", 32'(pops[2] - p0), 32'd5);

        // N=3 full and stalled, then reset for one cycle: everything flushed.
        out_ready_i[2] = 1'b0;
        acc = 0;
        budget = 10;
        while (acc < 3 && budget > 0) begin
            a_i[2] = 32'hABC0_0000 + 32'(acc); b_i[2] = 32'd1; in_valid_i[2] = 1'b1;
            cycle();
            if (rdy_seen[2]) acc++;
            budget--;
        end
        chk("fill_before_reset", 32'(acc), 32'd3);
        rst_n = 1'b0;
        cycle();
        chk1("flush_out_valid", out_valid_o[2], 1'b0);
`ifdef PIPE_ADD_DATA_RESET_EN
        chk("flush_c_zero", c_o[2], 32'd0);
`endif
        rst_n = 1'b1;
        in_valid_i[2] = 1'b0;
        cycle();
        chk1("flush_ready_after_release", rdy_seen[2], 1'b1);
        out_ready_i[2] = 1'b1;
        for (int n = 0; n < 6; n++) cycle();

        // N=1 full-throughput pass-through.
        p0 = pops[0];
        for (int n = 0; n < 20; n++) begin
            a_i[0] = $urandom; b_i[0] = $urandom;
            in_valid_i[0] = 1'b1; out_ready_i[0] = 1'b1;
            cycle();
            chk1($sformatf("passthrough_ready c%0d", n), rdy_seen[0], 1'b1);
        end
        chk("passthrough_emitted", 32'(pops[0] - p0), 32'd19);
        in_valid_i[0] = 1'b0;
        cycle();

        // Random traffic; N=2 sees out_ready toggling 1,0,1,0...
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < NI; i++) begin
                a_i[i] = $urandom; b_i[i] = $urandom;
                in_valid_i[i]  = 1'($urandom_range(0, 1));
                out_ready_i[i] = (i == 1) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
            end
            cycle();
        end
        for (int i = 0; i < NI; i++) begin
            in_valid_i[i] = 1'b0; out_ready_i[i] = 1'b1;
        end
        for (int n = 0; n < 8; n++) cycle();
        for (int i = 0; i < NI; i++)
            chk($sformatf("drained[%0d]", i), 32'(exp_q[i].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
